// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the ultrasonic echo emulator and range-detector side.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ultrasonic_pkg;

    // Measurement sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIG_HI = 3'd1,
        ST_DELAY   = 3'd2,
        ST_ECHO    = 3'd3,
        ST_HOLDOFF = 3'd4
    } echo_state_t;

    // Echo counter width; 255 << 8 plus jitter always fits
    localparam int ECHO_CNT_W = 18;

    // Defaults shared with the range-detector side
    localparam int DEF_MIN_TRIG    = 20;
    localparam int DEF_SCALE_SHIFT = 8;

endpackage

// File: rtl/echo_lfsr8.sv
// 8-bit maximal LFSR (taps 8,6,5,4) used to add echo-width jitter.
// Latency: new value one cycle after step.
// Backpressure: none; advances only when step is high.
module echo_lfsr8 (
    input  logic       osc_clk,
    input  logic       rst_n,
    input  logic       step,
    output logic [7:0] q
);

    // Fibonacci shift with feedback from bits 8,6,5,4 (1-based); reseeds to 8'hA5
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 8'hA5;
        end else if (step) begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04-style responder: validates trig width, waits BURST_DELAY, drives distance-coded echo.
// Latency: echo rises BURST_DELAY+1 cycles after trig falling-edge detection (3-flop sync ahead).
// Backpressure: re-triggers ignored while busy; build with ECHO_JITTER_EN for LFSR echo jitter.
module ultrasonic_echo_emulator
    import ultrasonic_pkg::*;
#(
    parameter int                     MIN_TRIG    = DEF_MIN_TRIG,
    parameter int                     BURST_DELAY = 40,
    parameter int                     SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter logic [ECHO_CNT_W-1:0]  TIMEOUT     = 18'h3FFFF,
    parameter int                     HOLDOFF     = 1000
) (
    input  logic       osc_clk,
    input  logic       rst_n,
    input  logic       trig,
    input  logic [7:0] distance,
    input  logic       enable,
    output logic       echo,
    output logic       busy,
    output logic       short_trig
);

    localparam logic [ECHO_CNT_W-1:0] MIN_C   = ECHO_CNT_W'(MIN_TRIG);
    localparam logic [ECHO_CNT_W-1:0] DELAY_C = ECHO_CNT_W'(BURST_DELAY);
    localparam logic [ECHO_CNT_W-1:0] HOLD_C  = ECHO_CNT_W'(HOLDOFF);

    logic                  trig_meta, trig_s, trig_d;
    logic                  rise_s, fall_s;
    echo_state_t           state, state_nxt;
    logic [ECHO_CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]            dist_latched, dist_nxt;
    logic                  echo_nxt, short_nxt, accept;
    logic [ECHO_CNT_W-1:0] base_len, echo_len;

    // Two-flop synchronizer plus a delay flop for edge detection
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_meta <= 1'b0;
            trig_s    <= 1'b0;
            trig_d    <= 1'b0;
        end else begin
            trig_meta <= trig;
            trig_s    <= trig_meta;
            trig_d    <= trig_s;
        end
    end

    assign rise_s = trig_s & ~trig_d;
    assign fall_s = ~trig_s & trig_d;

    assign base_len = {10'b0, dist_latched} << SCALE_SHIFT;

`ifdef ECHO_JITTER_EN
    logic [7:0] lfsr_q;

    echo_lfsr8 u_lfsr (
        .osc_clk (osc_clk),
        .rst_n   (rst_n),
        .step    (accept),
        .q       (lfsr_q)
    );

    // Zero distance means no target, so the timeout length stays exact
    assign echo_len = (dist_latched == 8'd0) ? TIMEOUT
                                             : base_len + {14'b0, lfsr_q[3:0]};
`else
    assign echo_len = (dist_latched == 8'd0) ? TIMEOUT : base_len;
`endif

    // State, shared phase counter, latched distance and registered outputs
    always_ff @(posedge osc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            dist_latched <= 8'd0;
            echo         <= 1'b0;
            short_trig   <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            dist_latched <= dist_nxt;
            echo         <= echo_nxt;
            short_trig   <= short_nxt;
        end
    end

    // Next-state logic; cnt is the trig width in TRIG_HI and elapsed cycles elsewhere
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dist_nxt  = dist_latched;
        echo_nxt  = 1'b0;
        short_nxt = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise_s && enable) begin
                    state_nxt = ST_TRIG_HI;
                    cnt_nxt   = 18'd1;
                end
            end
            ST_TRIG_HI: begin
                if (fall_s) begin
                    if (cnt >= MIN_C) begin
                        state_nxt = ST_DELAY;
                        cnt_nxt   = 18'd1;
                        dist_nxt  = distance;
                        accept    = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                        short_nxt = 1'b1;
                    end
                end else if (trig_s && cnt < MIN_C) begin
                    cnt_nxt = cnt + 18'd1;
                end
            end
            ST_DELAY: begin
                if (cnt >= DELAY_C) begin
                    state_nxt = ST_ECHO;
                    cnt_nxt   = 18'd1;
                    echo_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 18'd1;
                end
            end
            ST_ECHO: begin
                if (cnt >= echo_len) begin
                    state_nxt = ST_HOLDOFF;
                    cnt_nxt   = 18'd1;
                end else begin
                    cnt_nxt  = cnt + 18'd1;
                    echo_nxt = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (cnt >= HOLD_C) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 18'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign busy = (state == ST_DELAY) || (state == ST_ECHO) || (state == ST_HOLDOFF);

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Directed bench for ultrasonic_echo_emulator with an echo/short_trig scoreboard.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_ultrasonic_echo_emulator;

    localparam int          MIN_T = 20;
    localparam int          BD    = 40;
    localparam int          HO    = 1000;
    localparam logic [17:0] TO    = 18'd1500;

    logic       osc_clk = 1'b0;
    logic       rst_n;
    logic       trig;
    logic [7:0] distance;
    logic       enable;
    logic       echo;
    logic       busy;
    logic       short_trig;

    ultrasonic_echo_emulator #(
        .MIN_TRIG    (MIN_T),
        .BURST_DELAY (BD),
        .SCALE_SHIFT (8),
        .TIMEOUT     (TO),
        .HOLDOFF     (HO)
    ) dut (
        .osc_clk    (osc_clk),
        .rst_n      (rst_n),
        .trig       (trig),
        .distance   (distance),
        .enable     (enable),
        .echo       (echo),
        .busy       (busy),
        .short_trig (short_trig)
    );

    always #5 osc_clk = ~osc_clk;

    int cyc = 0;
    always @(posedge osc_clk) cyc <= cyc + 1;

    typedef struct {
        int rise;
        int width;
    } echo_exp_t;

    echo_exp_t exp_q[$];
    int        short_q[$];
    int        n_total = 0;
    int        n_pass  = 0;
    logic      expect_trunc = 1'b0;
    logic [7:0] ref_lfsr = 8'hA5;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge osc_clk);
            #1;
        end
    endtask

    function automatic int exp_len(input logic [7:0] d);
        int l;
        if (d == 8'd0) return int'(TO);
        l = int'(d) * 256;
`ifdef ECHO_JITTER_EN
        l = l + int'(ref_lfsr[3:0]);
`endif
        return l;
    endfunction

    // Raw trig pulse with no expectation attached
    task automatic pulse(input int hi);
        trig = 1'b1;
        tick(hi);
        trig = 1'b0;
    endtask

    // Trigger with expectation pushed to the scoreboard at the falling edge
    task automatic send(input int hi, input logic [7:0] d);
        echo_exp_t e;
        distance = d;
        pulse(hi);
        if (hi >= MIN_T) begin
            ref_lfsr = {ref_lfsr[6:0], ref_lfsr[7] ^ ref_lfsr[5] ^ ref_lfsr[4] ^ ref_lfsr[3]};
            e.rise  = cyc + BD + 3;
            e.width = exp_len(d);
            exp_q.push_back(e);
        end else begin
            short_q.push_back(cyc + 3);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        tick(5);
        while (busy && k < 6000) begin
            tick(1);
            k++;
        end
        check("wait_idle_timeout", int'(k >= 6000), 0);
        tick(5);
    endtask

    // Scoreboard monitor: pops expectations as the DUT produces pulses
    logic      echo_prev = 1'b0, short_prev = 1'b0, busy_prev = 1'b0;
    logic      busy_wait = 1'b0;
    int        wcnt = 0;
    int        busy_exp = 0;
    echo_exp_t cur;

    always @(negedge osc_clk) begin
        if (echo && !echo_prev) begin
            if (exp_q.size() == 0) begin
                check("echo_unexpected", 1, 0);
                cur.rise  = cyc;
                cur.width = -1;
            end else begin
                cur = exp_q.pop_front();
                check("echo_rise_cycle", cyc, cur.rise);
            end
            wcnt = 1;
        end else if (echo && echo_prev) begin
            wcnt++;
        end
        if (!echo && echo_prev) begin
            if (expect_trunc) begin
                expect_trunc = 1'b0;
            end else begin
                check("echo_width", wcnt, cur.width);
                busy_exp  = cyc + HO;
                busy_wait = 1'b1;
            end
        end
        if (busy_wait && !busy && busy_prev) begin
            check("busy_drop_cycle", cyc, busy_exp);
            busy_wait = 1'b0;
        end
        if (short_trig && !short_prev) begin
            if (short_q.size() == 0) check("short_unexpected", 1, 0);
            else check("short_trig_cycle", cyc, short_q.pop_front());
        end
        if (short_trig && short_prev) check("short_trig_width", 2, 1);
        echo_prev  = echo;
        short_prev = short_trig;
        busy_prev  = busy;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n    = 1'b0;
        trig     = 1'b0;
        distance = 8'd0;
        enable   = 1'b1;
        tick(3);
        check("reset_echo", int'(echo), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_short", int'(short_trig), 0);
        rst_n = 1'b1;
        tick(3);

        // Nominal: distance 4 -> 1024-cycle echo
        send(22, 8'h04);
        wait_idle();

        // Short trigger and the MIN_TRIG boundary
        send(10, 8'h04);
        tick(10);
        check("short_no_busy", int'(busy), 0);
        send(19, 8'h04);
        tick(10);
        check("short19_no_busy", int'(busy), 0);
        send(20, 8'h01);
        wait_idle();

        // No target -> timeout-length echo
        send(22, 8'h00);
        wait_idle();

        // Re-triggers during ECHO and HOLDOFF, distance change mid-echo
        send(22, 8'h02);
        tick(BD + 100);
        check("retrig_in_echo", int'(echo), 1);
        pulse(22);
        distance = 8'hFF;
        k = 0;
        while (echo && k < 2000) begin
            tick(1);
            k++;
        end
        check("echo_end_timeout", int'(k >= 2000), 0);
        tick(50);
        pulse(22);
        tick(5);
        pulse(5);
        check("retrig_holdoff_busy", int'(busy), 1);
        wait_idle();

        // Enable low blocks acceptance
        enable = 1'b0;
        distance = 8'h04;
        pulse(22);
        tick(60);
        check("disabled_no_busy", int'(busy), 0);
        enable = 1'b1;
        tick(5);

        // Enable dropped mid-measurement: measurement completes
        send(22, 8'h03);
        tick(10);
        enable = 1'b0;
        wait_idle();
        enable = 1'b1;
        tick(5);

        // Reset mid-echo truncates immediately, then a normal echo follows
        send(22, 8'h04);
        tick(BD + 200);
        check("pre_reset_echo", int'(echo), 1);
        expect_trunc = 1'b1;
        rst_n = 1'b0;
        #1;
        check("reset_mid_echo", int'(echo), 0);
        check("reset_mid_busy", int'(busy), 0);
        tick(2);
        rst_n    = 1'b1;
        ref_lfsr = 8'hA5;
        tick(3);
        send(22, 8'h04);
        wait_idle();

        // Consecutive distance-1 triggers (exercise jitter sequence when enabled)
        for (int i = 0; i < 16; i++) begin
            send(22, 8'h01);
            wait_idle();
        end

        tick(20);
        check("echo_queue_empty", exp_q.size(), 0);
        check("short_queue_empty", short_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ultrasonic_echo_emulator.md
# ultrasonic_echo_emulator

Responder-side model of an HC-SR04-style ultrasonic ranging sensor, used on the board in place of a real transducer for closed-loop bring-up of the range-detector logic. It watches the `trig` line driven by the ranging initiator and validates the trigger pulse width. After a fixed burst delay it drives an `echo` pulse whose length encodes a programmed target distance. A no-target distance code produces a timeout-length echo, and a holdoff window rejects re-triggers while a measurement is in flight.

## Interface
Parameters:
- `MIN_TRIG`, 20: minimum synchronized trigger high time, in cycles, for a trigger to be accepted.
- `BURST_DELAY`, 40: cycles from detection of the trigger falling edge to the echo rising.
- `SCALE_SHIFT`, 8: echo length is `distance << SCALE_SHIFT` cycles.
- `TIMEOUT`, 18'h3FFFF: echo length, in cycles, when `distance == 0`.
- `HOLDOFF`, 1000: cycles after echo falls during which triggers are ignored.

Ports:
- `osc_clk`, in, 1: single clock for the whole block.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `trig`, in, 1: trigger from the initiator; treated as asynchronous.
- `distance`, in, 8: target distance code, sampled once per accepted trigger.
- `enable`, in, 1: when low, triggers are not accepted.
- `echo`, out, 1: emulated echo pulse, registered.
- `busy`, out, 1: high from trigger acceptance through the end of `HOLDOFF`.
- `short_trig`, out, 1: one-cycle pulse flagging a trigger that fell before reaching `MIN_TRIG`.

## Operation
- Synchronization and edge detection:
  - `trig` passes through a 2-flop synchronizer to give `trig_s`.
  - A third flop gives `trig_d`; edges are detected from `trig_s` against `trig_d`.
- States of the FSM, all in `osc_clk`: `IDLE`, `TRIG_HI`, `DELAY`, `ECHO`, `HOLDOFF`.
- `IDLE`:
  - A rising edge of `trig_s` while `enable` is high → `TRIG_HI`; the width counter starts at 1.
  - A rising edge with `enable` low is ignored.
- `TRIG_HI`:
  - The width counter increments each cycle `trig_s` stays high, saturating at `MIN_TRIG`.
  - On the falling edge with width ≥ `MIN_TRIG` → `DELAY`; `distance` is latched.
  - On the falling edge with width < `MIN_TRIG` → `IDLE`, and `short_trig` pulses for 1 cycle.
- `DELAY`: counts `BURST_DELAY` cycles, then → `ECHO`.
- `ECHO`:
  - `echo` is high for exactly L cycles, then → `HOLDOFF`.
  - L = `{10'b0, dist_latched} << SCALE_SHIFT`, computed 18 bits wide.
  - When `dist_latched == 0`, L = `TIMEOUT`.
- `HOLDOFF`:
  - Counts `HOLDOFF` cycles, then → `IDLE`.
  - Any trig activity in this state is ignored; no `short_trig` is raised.
- Activity during the measurement: edges on `trig` in `DELAY` or `ECHO` are ignored, and `distance` changes after the latch have no effect.
- `enable` deasserted mid-measurement: the measurement in progress completes normally; only new acceptances are blocked.
- `busy` is high in `DELAY`, `ECHO` and `HOLDOFF`.
- Reset, asserted at any time, with immediate effect:
  - State goes to `IDLE`; all counters and synchronizer flops clear.
  - `echo` = 0, `busy` = 0, `short_trig` = 0.
  - An echo in progress is truncated.

## Timing
- Trigger input latency: 2 cycles from a `trig` pin change to `trig_s`, and 1 further cycle to the edge-detect decision.
- Echo start: let the cycle at which the falling edge is detected be E. `echo` rises at E + `BURST_DELAY` + 1.
- Echo width: `echo` is high for exactly L consecutive cycles.
- Return to `IDLE`: `busy` drops, and triggers are accepted again, `HOLDOFF` cycles after `echo` falls.
- Pulse widths: `short_trig` is exactly 1 cycle wide; `echo` has no glitches between its edges.
- Sizing: the echo counter is 18 bits; L never overflows because max(255 << 8) < 2^18.

## Configuration
- `ECHO_JITTER_EN` defined:
  - An 8-bit maximal LFSR (taps 8,6,5,4, seed 8'hA5 on reset) advances once per accepted trigger.
  - Its low 4 bits are added to L, giving 0–15 cycles of extra echo width to emulate measurement noise.
  - The addition is not applied when `dist_latched == 0`.
- `ECHO_JITTER_EN` undefined: L is exact and no LFSR is instantiated.

## Structure
- Shared package `ultrasonic_pkg`:
  - State enum `echo_state_t`.
  - Echo counter width constant `ECHO_CNT_W = 18`.
  - Default constants shared with the range-detector side: trigger minimum and scale shift.
- One sub-module, `echo_lfsr8`, instantiated only under `ECHO_JITTER_EN`.

## Test plan
- Nominal echo: defaults, `distance` = 8'h04, trig high for 22 cycles → `echo` rises 41 cycles after falling-edge detection and stays high 1024 cycles; `busy` drops 1000 cycles after `echo` falls.
- Short trigger: trig high for 10 cycles → no `echo`, a 1-cycle `short_trig` pulse, state returns to `IDLE`.
- No target: `distance` = 0 → `echo` high for 262143 cycles.
- Re-triggers ignored: pulse trig during `ECHO` and again during `HOLDOFF` → `echo` width is unchanged and no second echo is produced; `distance` changed mid-echo has no effect.
- Reset mid-echo: assert `rst_n` low during `ECHO` → `echo` = 0 and `busy` = 0 immediately; after release, a 22-cycle trigger produces a normal echo.
- Jitter build, `ECHO_JITTER_EN` defined, `distance` = 8'h01: 16 consecutive triggers → each echo width lies in 256–271 and the sequence matches a reference LFSR seeded with 8'hA5.
